eth_vlan_pkt_src: RTL

//  Synthesisable, parametrised Ethernet frame source with optional 802.1Q tag and a payload-length sweep.

---
 rtl/eth_vlan_pkt_src_if.sv | 23 ++
 rtl/eth_vlan_pkt_src.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_vlan_pkt_src_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_vlan_pkt_src_if
// Description : Valid/Ready/Sop/Eop/Data/Keep frame stream bundle.
//               The byte-0 lane is the MSB lane of data; keep MSB = byte 0.
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_vlan_pkt_src_if #(
  parameter int DATA_W = 32
);
  localparam int KEEP_W = DATA_W / 8;

  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;
  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;

  modport master (output valid, sop, eop, data, keep, input ready);
  modport slave  (input valid, sop, eop, data, keep, output ready);
endinterface
`default_nettype wire

// File: rtl/eth_vlan_pkt_src.sv
`default_nettype none
// ============================================================================
// Module      : eth_vlan_pkt_src
// Description : Ethernet frame source with optional 802.1Q tag, a saturating
//               payload-length sweep, inter-packet gap, downstream
//               backpressure and run completion status.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_vlan_pkt_src #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 16,
  parameter int MAX_LEN = 1500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_vlan_en,
  input  logic [2:0]         cfg_pcp,
  input  logic [11:0]        cfg_vid,
  input  logic [47:0]        cfg_da,
  input  logic [47:0]        cfg_sa,
  input  logic [15:0]        cfg_eth_type,
  input  logic [7:0]         cfg_seed,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [LEN_W-1:0]   cfg_step,
  input  logic [CNT_W-1:0]   cfg_pkt_num,
  input  logic [7:0]         cfg_ipg,
  eth_vlan_pkt_src_if.master tx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pkt_cnt
);
  localparam int KEEP_W    = DATA_W / 8;
  localparam int POS_W     = LEN_W + 2;   // holds header + saturated payload length
  localparam int HDR_BYTES = 18;
  localparam logic [LEN_W:0] MAX_L = (LEN_W + 1)'(MAX_LEN);
  localparam logic [LEN_W:0] ONE_L = (LEN_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched run configuration
  logic             vlan_en;
  logic [2:0]       pcp;
  logic [11:0]      vid;
  logic [47:0]      da;
  logic [47:0]      sa;
  logic [15:0]      eth_type;
  logic [7:0]       seed;
  logic [LEN_W-1:0] step;
  logic [CNT_W-1:0] pkt_num;
  logic [7:0]       ipg;

  // Frame progress
  logic [LEN_W:0]   cur_len;      // payload length of the frame being sent
  logic [POS_W-1:0] pos;          // byte offset of the current beat
  logic [7:0]       gap_cnt;

  logic [8*HDR_BYTES-1:0] hdr_vec;
  logic [POS_W-1:0]       hdr_len;
  logic [POS_W-1:0]       frame_len;
  logic [LEN_W:0]         init_len;
  logic [LEN_W:0]         len_sum;
  logic [LEN_W:0]         next_len;
  logic                   beat_valid;
  logic                   fire;
  logic                   last_beat;
  logic                   last_pkt;
  logic [DATA_W-1:0]      beat_data;
  logic [KEEP_W-1:0]      beat_keep;

  // First-frame length (0 promoted to 1) and the saturating sweep increment
  always_comb begin
    init_len = {1'b0, cfg_len};
    if (cfg_len == '0) begin
      init_len = ONE_L;
    end else if (init_len > MAX_L) begin
      init_len = MAX_L;
    end
    // cur_len never exceeds MAX_LEN, so the sum cannot wrap in LEN_W+1 bits
    len_sum  = cur_len + {1'b0, step};
    next_len = (len_sum > MAX_L) ? MAX_L : len_sum;
  end

  // Header image left-aligned: byte 0 sits in the top byte of hdr_vec
  always_comb begin
    if (vlan_en) begin
      hdr_vec = {da, sa, 16'h8100, pcp, 1'b0, vid, eth_type};
      hdr_len = POS_W'(18);
    end else begin
      hdr_vec = {da, sa, eth_type, 32'h0};
      hdr_len = POS_W'(14);
    end
    frame_len = hdr_len + POS_W'(cur_len);
  end

  assign beat_valid = (state == ST_SEND);
  assign fire       = beat_valid && tx.ready;
  assign last_beat  = (pos + POS_W'(KEEP_W)) >= frame_len;
  assign last_pkt   = ({1'b0, pkt_cnt} + (CNT_W + 1)'(1)) == {1'b0, pkt_num};

  for (genvar j = 0; j < KEEP_W; j++) begin : g_lane
    logic [POS_W-1:0] idx;
    logic             lane_on;
    logic [7:0]       hdr_byte;
    logic [7:0]       pay_byte;

    assign idx      = pos + POS_W'(j);
    assign lane_on  = beat_valid && (idx < frame_len);
    assign pay_byte = seed + idx[7:0] - hdr_len[7:0];

    // Header byte lookup for this lane's frame offset
    always_comb begin
      hdr_byte = 8'h00;
      for (int b = 0; b < HDR_BYTES; b++) begin
        if (idx == POS_W'(b)) begin
          hdr_byte = hdr_vec[8*(HDR_BYTES-1-b) +: 8];
        end
      end
    end

    assign beat_data[DATA_W-1-8*j -: 8] = lane_on ? ((idx < hdr_len) ? hdr_byte : pay_byte) : 8'h00;
    assign beat_keep[KEEP_W-1-j]        = lane_on;
  end

  assign tx.valid = beat_valid;
  assign tx.sop   = beat_valid && (pos == '0);
  assign tx.eop   = beat_valid && last_beat;
  assign tx.data  = beat_data;
  assign tx.keep  = beat_keep;
  assign busy     = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start && (cfg_pkt_num != '0)) begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (fire && last_beat) begin
          if (last_pkt) begin
            state_nxt = ST_IDLE;
          end else if (ipg != 8'd0) begin
            state_nxt = ST_GAP;
          end else begin
            state_nxt = ST_SEND;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt <= 8'd1) begin
          state_nxt = ST_SEND;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture configuration on an accepted Start; later cfg changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vlan_en  <= 1'b0;
      pcp      <= '0;
      vid      <= '0;
      da       <= '0;
      sa       <= '0;
      eth_type <= '0;
      seed     <= '0;
      step     <= '0;
      pkt_num  <= '0;
      ipg      <= '0;
    end else if ((state == ST_IDLE) && start) begin
      vlan_en  <= cfg_vlan_en;
      pcp      <= cfg_pcp;
      vid      <= cfg_vid;
      da       <= cfg_da;
      sa       <= cfg_sa;
      eth_type <= cfg_eth_type;
      seed     <= cfg_seed;
      step     <= cfg_step;
      pkt_num  <= cfg_pkt_num;
      ipg      <= cfg_ipg;
    end
  end

  // Beat offset, frame length sweep, gap timer, packet counter and Done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos     <= '0;
      cur_len <= '0;
      gap_cnt <= '0;
      pkt_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == ST_IDLE) && start) begin
        pos     <= '0;
        cur_len <= init_len;
        pkt_cnt <= '0;
        done    <= (cfg_pkt_num == '0);
      end else if (fire) begin
        if (last_beat) begin
          pos     <= '0;
          cur_len <= next_len;
          gap_cnt <= ipg;
          pkt_cnt <= pkt_cnt + CNT_W'(1);
          done    <= last_pkt;
        end else begin
          pos <= pos + POS_W'(KEEP_W);
        end
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
